// File: rtl/hazard3_zcmp_sequencer_pkg.sv
// Shared definitions for the Zcmp micro-op sequencer: Zcmp match/mask
// constants, the base RV32I opcodes used by the expansion, sequencer states,
// the per-uop flag bundle and small instruction-encoding helpers.
package hazard3_zcmp_sequencer_pkg;

    // cm.push/pop family: bits [15:8] select the op, [1:0] = 2'b10
    localparam logic [15:0] ZCMP_PP_MASK   = 16'hFF03;
    localparam logic [15:0] MATCH_PUSH     = 16'hB802;
    localparam logic [15:0] MATCH_POP      = 16'hBA02;
    localparam logic [15:0] MATCH_POPRETZ  = 16'hBC02;
    localparam logic [15:0] MATCH_POPRET   = 16'hBE02;
    // cm.mvsa01 / cm.mva01s: bits [6:5] select direction
    localparam logic [15:0] ZCMP_MV_MASK   = 16'hFC63;
    localparam logic [15:0] MATCH_MVSA01   = 16'hAC22;
    localparam logic [15:0] MATCH_MVA01S   = 16'hAC62;

    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_JALR  = 7'h67;

    localparam logic [4:0] X_ZERO = 5'd0;
    localparam logic [4:0] X_RA   = 5'd1;
    localparam logic [4:0] X_SP   = 5'd2;
    localparam logic [4:0] X_A0   = 5'd10;
    localparam logic [4:0] X_A1   = 5'd11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LS, ST_ZERO, ST_RET, ST_ADJ, ST_MV1, ST_MV2, ST_ILL
    } state_t;

    typedef enum logic [2:0] {
        OP_PUSH, OP_POP, OP_POPRET, OP_POPRETZ, OP_MVSA01, OP_MVA01S, OP_ILL
    } op_t;

    typedef struct packed {
        logic first;
        logic last;
        logic no_pc_update;
        logic atomic;
        logic illegal;
    } uop_flags_t;

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
    endfunction

    // Zcmp sreg index -> x8/x9 for 0/1, x18..x23 for 2..7
    function automatic logic [4:0] sreg(input logic [2:0] r);
        return {|r[2:1], ~|r[2:1], r};
    endfunction

endpackage

// File: rtl/hazard3_zcmp_sequencer_uop_gen.sv
// Combinational uop generator. Given the instruction, the state of the uop
// to be produced and the load/store counter, returns that uop, its flags and
// the state/counter that follow it. A state of ST_IDLE means "first uop of a
// freshly offered instruction": the entry state is decoded here.
//   instr_i      : 16-bit Zcmp instruction
//   state_i/ctr_i: current sequencer position
//   uop_o/flags_o: generated uop and flags
//   state_nxt_o/ctr_nxt_o: position after this uop
module hazard3_zcmp_uop_gen
    import hazard3_zcmp_sequencer_pkg::*;
#(
    parameter int MAX_RLIST  = 15,
    parameter bit EN_POPRETZ = 1'b1,
    parameter bit EN_MV      = 1'b1
) (
    input  logic [15:0] instr_i,
    input  state_t      state_i,
    input  logic [3:0]  ctr_i,
    output logic [31:0] uop_o,
    output uop_flags_t  flags_o,
    output state_t      state_nxt_o,
    output logic [3:0]  ctr_nxt_o
);
    localparam logic [4:0] MAXR = 5'(MAX_RLIST);

    op_t         op;
    state_t      st;
    logic [3:0]  rlist, n, rem;
    logic [11:0] base, adj, off;
    logic [4:0]  ls_reg;
    logic        rlist_ok, pp_match;

    always_comb begin
        rlist    = instr_i[7:4];
        rlist_ok = (rlist >= 4'd4) && ({1'b0, rlist} <= MAXR);
        pp_match = ((instr_i & ZCMP_PP_MASK) == MATCH_PUSH) || ((instr_i & ZCMP_PP_MASK) == MATCH_POP)
                || ((instr_i & ZCMP_PP_MASK) == MATCH_POPRET)
                || ((instr_i & ZCMP_PP_MASK) == MATCH_POPRETZ && EN_POPRETZ);
        op = OP_ILL;
        if (pp_match && rlist_ok) begin
            case (instr_i & ZCMP_PP_MASK)
                MATCH_PUSH:    op = OP_PUSH;
                MATCH_POP:     op = OP_POP;
                MATCH_POPRET:  op = OP_POPRET;
                default:       op = OP_POPRETZ;
            endcase
        end else if (EN_MV && (instr_i & ZCMP_MV_MASK) == MATCH_MVSA01) begin
            op = OP_MVSA01;
        end else if (EN_MV && (instr_i & ZCMP_MV_MASK) == MATCH_MVA01S) begin
            op = OP_MVA01S;
        end

        n    = (rlist == 4'd15) ? 4'd13 : rlist - 4'd3;
        base = (rlist == 4'd15) ? 12'd64 : (rlist >= 4'd12) ? 12'd48 :
               (rlist >= 4'd8)  ? 12'd32 : 12'd16;
        adj  = base + {6'd0, instr_i[3:2], 4'd0};
        rem  = n - ctr_i;
        off  = {6'd0, rem, 2'b00};
        ls_reg = (ctr_i == 4'd0) ? X_RA : (ctr_i == 4'd1) ? 5'd8 :
                 (ctr_i == 4'd2) ? 5'd9 : 5'(ctr_i) + 5'd15;

        if (state_i == ST_IDLE)
            st = (op == OP_ILL) ? ST_ILL : (op == OP_MVSA01 || op == OP_MVA01S) ? ST_MV1 : ST_LS;
        else
            st = state_i;

        uop_o       = 32'h0;
        flags_o     = '0;
        flags_o.first = (state_i == ST_IDLE);
        state_nxt_o = ST_IDLE;
        ctr_nxt_o   = ctr_i;

        case (st)
            ST_LS: begin
                uop_o = (op == OP_PUSH) ? enc_sw(ls_reg, X_SP, 12'd0 - off)
                                        : enc_i(OPC_LOAD, 3'b010, ls_reg, X_SP, adj - off);
                flags_o.no_pc_update = 1'b1;
                if (ctr_i == n - 4'd1) begin
                    ctr_nxt_o   = 4'd0;
                    state_nxt_o = (op == OP_POPRET) ? ST_RET : (op == OP_POPRETZ) ? ST_ZERO : ST_ADJ;
                end else begin
                    ctr_nxt_o   = ctr_i + 4'd1;
                    state_nxt_o = ST_LS;
                end
            end
            ST_ZERO: begin
                uop_o = enc_i(OPC_OPIMM, 3'b000, X_A0, X_ZERO, 12'd0);
                flags_o.no_pc_update = 1'b1;
                flags_o.atomic       = 1'b1;
                state_nxt_o = ST_RET;
            end
            ST_RET: begin
                // Retires popret/popretz: the PC is redirected here
                uop_o = enc_i(OPC_JALR, 3'b000, X_ZERO, X_RA, 12'd0);
                flags_o.atomic = 1'b1;
                state_nxt_o = ST_ADJ;
            end
            ST_ADJ: begin
                uop_o = enc_i(OPC_OPIMM, 3'b000, X_SP, X_SP, (op == OP_PUSH) ? 12'd0 - adj : adj);
                flags_o.last         = 1'b1;
                flags_o.atomic       = 1'b1;
                flags_o.no_pc_update = (op == OP_POPRET || op == OP_POPRETZ);
            end
            ST_MV1: begin
                uop_o = (op == OP_MVSA01) ? enc_i(OPC_OPIMM, 3'b000, sreg(instr_i[9:7]), X_A0, 12'd0)
                                          : enc_i(OPC_OPIMM, 3'b000, X_A0, sreg(instr_i[9:7]), 12'd0);
                flags_o.no_pc_update = 1'b1;
                state_nxt_o = ST_MV2;
            end
            ST_MV2: begin
                uop_o = (op == OP_MVSA01) ? enc_i(OPC_OPIMM, 3'b000, sreg(instr_i[4:2]), X_A1, 12'd0)
                                          : enc_i(OPC_OPIMM, 3'b000, X_A1, sreg(instr_i[4:2]), 12'd0);
                flags_o.last   = 1'b1;
                flags_o.atomic = 1'b1;
            end
            ST_ILL: begin
                uop_o = {16'h0, instr_i};
                flags_o.last    = 1'b1;
                flags_o.illegal = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/hazard3_zcmp_sequencer.sv
// Zcmp micro-op sequencer top. Accepts one 16-bit Zcmp instruction over
// instr_in_valid/ready and emits a registered stream of RV32I uops over
// uop_valid/ready, with first/last/no_pc_update/atomic/illegal flags.
//   clk, rst_n         : clock, async active-low reset
//   instr_in*          : instruction handshake
//   uop_out, uop_*     : registered uop output and flags
//   flush              : abort current sequence, drop pending uop
module hazard3_zcmp_sequencer
    import hazard3_zcmp_sequencer_pkg::*;
#(
    parameter int MAX_RLIST  = 15,
    parameter bit EN_POPRETZ = 1'b1,
    parameter bit EN_MV      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic        instr_in_valid,
    output logic        instr_in_ready,
    output logic [31:0] uop_out,
    output logic        uop_valid,
    input  logic        uop_ready,
    output logic        uop_first,
    output logic        uop_last,
    output logic        uop_no_pc_update,
    output logic        uop_atomic,
    output logic        uop_illegal,
    input  logic        flush
);
    // state_q is the position of the *next* uop to generate; ST_IDLE means
    // everything has been generated (the last uop may still sit in the
    // output register waiting for uop_ready).
    state_t      state_q, state_d, gen_state;
    logic [3:0]  ctr_q, ctr_d, gen_ctr;
    logic [15:0] instr_q, cur_instr;
    logic [31:0] uop_q, gen_uop;
    uop_flags_t  flags_q, gen_flags;
    logic        valid_q, adv, idle, gen_go;

    assign idle      = (state_q == ST_IDLE);
    assign adv       = !valid_q || uop_ready;        // output register free this edge
    assign cur_instr = idle ? instr_in : instr_q;    // first uop decodes straight from the input
    assign instr_in_ready = idle && adv && !flush;
    assign gen_go    = !flush && adv && (!idle || instr_in_valid);

    hazard3_zcmp_uop_gen #(
        .MAX_RLIST  (MAX_RLIST),
        .EN_POPRETZ (EN_POPRETZ),
        .EN_MV      (EN_MV)
    ) u_gen (
        .instr_i     (cur_instr),
        .state_i     (state_q),
        .ctr_i       (ctr_q),
        .uop_o       (gen_uop),
        .flags_o     (gen_flags),
        .state_nxt_o (gen_state),
        .ctr_nxt_o   (gen_ctr)
    );

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        if (flush) begin
            state_d = ST_IDLE;
            ctr_d   = 4'd0;
        end else if (gen_go) begin
            state_d = gen_state;
            ctr_d   = gen_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctr_q   <= 4'd0;
            instr_q <= 16'h0;
            uop_q   <= 32'h0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            if (idle && gen_go)
                instr_q <= instr_in;
            if (gen_go) begin
                uop_q   <= gen_uop;
                flags_q <= gen_flags;
            end
            if (flush)
                valid_q <= 1'b0;
            else if (adv)
                valid_q <= gen_go;
        end
    end

    assign uop_out          = uop_q;
    assign uop_valid        = valid_q;
    assign uop_first        = flags_q.first;
    assign uop_last         = flags_q.last;
    assign uop_no_pc_update = flags_q.no_pc_update;
    assign uop_atomic       = flags_q.atomic;
    assign uop_illegal      = flags_q.illegal;
endmodule

// File: tb/tb_hazard3_zcmp_sequencer.sv
module tb_hazard3_zcmp_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] instr_in = 16'h0;
    logic        instr_in_valid = 1'b0, uop_ready = 1'b0, flush = 1'b0;
    logic        instr_in_ready, uop_valid, uop_first, uop_last;
    logic        uop_no_pc_update, uop_atomic, uop_illegal;
    logic [31:0] uop_out;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    hazard3_zcmp_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_in_valid(instr_in_valid),
        .instr_in_ready(instr_in_ready), .uop_out(uop_out), .uop_valid(uop_valid),
        .uop_ready(uop_ready), .uop_first(uop_first), .uop_last(uop_last),
        .uop_no_pc_update(uop_no_pc_update), .uop_atomic(uop_atomic),
        .uop_illegal(uop_illegal), .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] u, input logic f, input logic l,
                        input logic npc, input logic at);
        chk({tag, ".valid"}, 32'(uop_valid), 32'd1);
        chk({tag, ".uop"}, uop_out, u);
        chk({tag, ".first"}, 32'(uop_first), 32'(f));
        chk({tag, ".last"}, 32'(uop_last), 32'(l));
        chk({tag, ".npc"}, 32'(uop_no_pc_update), 32'(npc));
        chk({tag, ".atomic"}, 32'(uop_atomic), 32'(at));
        chk({tag, ".ill"}, 32'(uop_illegal), 32'd0);
    endtask

    function automatic logic [31:0] sw_sp(input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] lw_sp(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd2, 3'b010, rd, 7'h03};
    endfunction

    initial begin
        int rmap [13];
        logic [31:0] e;
        rmap = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};

        // reset state
        #12;
        chk("rst.valid", 32'(uop_valid), 32'd0);
        chk("rst.uop", uop_out, 32'h0);
        chk("rst.flags", 32'({uop_first, uop_last, uop_no_pc_update, uop_atomic, uop_illegal}), 32'd0);
        chk("rst.irdy", 32'(instr_in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        // cm.push {ra},-16 then back-to-back cm.popretz {ra},16
        @(negedge clk); instr_in = 16'hB842; instr_in_valid = 1'b1; uop_ready = 1'b1;
        #1 chk("push.irdy0", 32'(instr_in_ready), 32'd1);
        @(negedge clk); instr_in_valid = 1'b0;
        beat("push.b1", 32'hFE112E23, 1, 0, 1, 0);
        chk("push.b1.irdy", 32'(instr_in_ready), 32'd0);
        @(negedge clk);
        beat("push.b2", 32'hFF010113, 0, 1, 0, 1);
        chk("push.b2.irdy", 32'(instr_in_ready), 32'd1);
        instr_in = 16'hBC42; instr_in_valid = 1'b1;
        @(negedge clk); instr_in_valid = 1'b0;
        beat("prz.b1", 32'h00C12083, 1, 0, 1, 0);
        @(negedge clk); beat("prz.b2", 32'h00000513, 0, 0, 1, 1);
        @(negedge clk); beat("prz.b3", 32'h00008067, 0, 0, 0, 1);
        @(negedge clk); beat("prz.b4", 32'h01010113, 0, 1, 1, 1);
        @(negedge clk); chk("prz.done", 32'(uop_valid), 32'd0);

        // cm.mvsa01 s0,s1 with backpressure on beat 1
        instr_in = 16'hAC26; instr_in_valid = 1'b1;
        @(negedge clk); instr_in_valid = 1'b0;
        beat("mv.b1", 32'h00050413, 1, 0, 1, 0);
        uop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            beat("mv.hold", 32'h00050413, 1, 0, 1, 0);
            chk("mv.hold.irdy", 32'(instr_in_ready), 32'd0);
        end
        uop_ready = 1'b1;
        @(negedge clk); beat("mv.b2", 32'h00058493, 0, 1, 0, 1);
        @(negedge clk); chk("mv.done", 32'(uop_valid), 32'd0);

        // cm.push rlist=15 spimm=3: 13 stores then addi sp,sp,-112
        instr_in = 16'hB8FE; instr_in_valid = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 0) instr_in_valid = 1'b0;
            e = (k == 0) ? 32'hFC112623 : sw_sp(5'(rmap[k]), 12'(0 - (13 - k) * 4));
            beat("p15.st", e, k == 0, 0, 1, 0);
            chk("p15.irdy", 32'(instr_in_ready), 32'd0);
        end
        @(negedge clk);
        beat("p15.adj", 32'hF9010113, 0, 1, 0, 1);
        chk("p15.adj.irdy", 32'(instr_in_ready), 32'd1);
        @(negedge clk); chk("p15.done", 32'(uop_valid), 32'd0);

        // cm.pop rlist=15 flushed at beat 5, then a fresh pop {ra,s0},16
        instr_in = 16'hBAF2; instr_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) instr_in_valid = 1'b0;
            e = (k == 4) ? 32'h01C12983 : lw_sp(5'(rmap[k]), 12'(64 - (13 - k) * 4));
            beat("fl.ld", e, k == 0, 0, 1, 0);
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl.valid", 32'(uop_valid), 32'd0);
        flush = 1'b0;
        #1 chk("fl.irdy", 32'(instr_in_ready), 32'd1);
        instr_in = 16'hBA52; instr_in_valid = 1'b1;
        @(negedge clk); instr_in_valid = 1'b0;
        beat("pop2.b1", 32'h00812083, 1, 0, 1, 0);
        @(negedge clk); beat("pop2.b2", 32'h00C12403, 0, 0, 1, 0);
        @(negedge clk); beat("pop2.b3", 32'h01010113, 0, 1, 0, 1);
        @(negedge clk); chk("pop2.done", 32'(uop_valid), 32'd0);

        // illegal: push with rlist=3
        instr_in = 16'hB832; instr_in_valid = 1'b1;
        @(negedge clk); instr_in_valid = 1'b0;
        chk("ill.valid", 32'(uop_valid), 32'd1);
        chk("ill.uop", uop_out, 32'h0000B832);
        chk("ill.ill", 32'(uop_illegal), 32'd1);
        chk("ill.last", 32'(uop_last), 32'd1);
        chk("ill.first", 32'(uop_first), 32'd1);
        @(negedge clk); chk("ill.done", 32'(uop_valid), 32'd0);

        // flush beats a simultaneous offer while idle
        instr_in = 16'hB842; instr_in_valid = 1'b1; flush = 1'b1;
        #1 chk("fi.irdy", 32'(instr_in_ready), 32'd0);
        @(negedge clk);
        chk("fi.valid", 32'(uop_valid), 32'd0);
        instr_in_valid = 1'b0; flush = 1'b0;

        // reset mid-sequence
        instr_in = 16'hB8FE; instr_in_valid = 1'b1;
        @(negedge clk); instr_in_valid = 1'b0;
        @(negedge clk);
        beat("rs.b2", sw_sp(5'd8, 12'hFD0), 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("rs.valid", 32'(uop_valid), 32'd0);
        chk("rs.uop", uop_out, 32'h0);
        chk("rs.irdy", 32'(instr_in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        instr_in = 16'hB842; instr_in_valid = 1'b1;
        @(negedge clk); instr_in_valid = 1'b0;
        beat("rs.after", 32'hFE112E23, 1, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
